// File: rtl/ram_stream_reader_if.sv
// Valid/ready word stream between the RAM reader and the PE-array feeder.
// The master drives valid/data/last and the slave drives ready.
interface ram_stream_reader_if #(
    parameter int dw = 16
) ();
    logic          valid;
    logic          ready;
    logic [dw-1:0] data;
    logic          last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/ram_stream_reader.sv
// Walks a contiguous RAM window (1-cycle read latency) and streams the words out through a 2-entry skid FIFO.
// Optional macro RAM_STREAM_STRIDE_EN adds a stride_i port; otherwise the address step is fixed at 1.
//
// state     | meaning
// ST_IDLE   | waiting for start_i
// ST_RUN    | issuing reads and draining the FIFO
// ST_FINISH | one-cycle done pulse, back to idle next cycle
module ram_stream_reader #(
    parameter int aw = 16,
    parameter int dw = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [aw-1:0]       base_addr_i,
    input  logic [aw-1:0]       len_i,
`ifdef RAM_STREAM_STRIDE_EN
    input  logic [aw-1:0]       stride_i,
`endif
    output logic                busy_o,
    output logic                done_o,
    output logic [aw-1:0]       ram_addr_o,
    output logic                ram_we_o,
    input  logic [dw-1:0]       ram_dout_i,
    ram_stream_reader_if.master out_if
);

    localparam logic [aw-1:0] one_w = aw'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [aw-1:0] addr_ptr_q, addr_ptr_d;
    logic [aw-1:0] rem_issue_q, rem_issue_d;
    logic [aw-1:0] rem_out_q, rem_out_d;
    logic [aw-1:0] ram_addr_q;
    logic [aw-1:0] step;
    logic          inflight_q;
    logic [dw-1:0] fifo_mem_q [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    fifo_count_q;
    logic          push, pop, issue;
    logic [2:0]    occ;

`ifdef RAM_STREAM_STRIDE_EN
    logic [aw-1:0] stride_q, stride_d;
    assign step = stride_q;
`else
    assign step = one_w;
`endif

    // Count the read in flight as occupied so the FIFO can never overflow.
    assign pop   = (fifo_count_q != 2'd0) && out_if.ready;
    assign push  = inflight_q;
    assign occ   = {1'b0, fifo_count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = (state_q == ST_RUN) && (rem_issue_q != '0) && (occ < 3'd2);

    always_comb begin
        state_d     = state_q;
        addr_ptr_d  = addr_ptr_q;
        rem_issue_d = rem_issue_q;
        rem_out_d   = rem_out_q;
`ifdef RAM_STREAM_STRIDE_EN
        stride_d    = stride_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_ptr_d  = base_addr_i;
                    rem_issue_d = len_i;
                    rem_out_d   = len_i;
`ifdef RAM_STREAM_STRIDE_EN
                    stride_d    = stride_i;
`endif
                    state_d     = (len_i == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_ptr_d  = addr_ptr_q + step;
                    rem_issue_d = rem_issue_q - one_w;
                end
                if (pop) begin
                    rem_out_d = rem_out_q - one_w;
                    if (rem_out_q == one_w) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_ptr_q   <= '0;
            rem_issue_q  <= '0;
            rem_out_q    <= '0;
            ram_addr_q   <= '0;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            fifo_count_q <= 2'd0;
`ifdef RAM_STREAM_STRIDE_EN
            stride_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_ptr_q   <= addr_ptr_d;
            rem_issue_q  <= rem_issue_d;
            rem_out_q    <= rem_out_d;
            ram_addr_q   <= ram_addr_o;
            inflight_q   <= issue;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            fifo_count_q <= fifo_count_q + {1'b0, push} - {1'b0, pop};
`ifdef RAM_STREAM_STRIDE_EN
            stride_q     <= stride_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= ram_dout_i;
        end
    end

    // The RAM samples the address combinationally in the issue cycle; it holds otherwise.
    assign ram_addr_o   = issue ? addr_ptr_q : ram_addr_q;
    assign ram_we_o     = 1'b0;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_FINISH);
    assign out_if.valid = (fifo_count_q != 2'd0);
    assign out_if.data  = fifo_mem_q[rd_ptr_q];
    assign out_if.last  = out_if.valid && (rem_out_q == one_w);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: expected words are queued at start and popped on each handshake.
module tb_ram_stream_reader;
    localparam int aw = 16;
    localparam int dw = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic [15:0]   base_addr, len;
    logic          busy, done, ram_we;
    logic [15:0]   ram_addr, ram_dout;
`ifdef RAM_STREAM_STRIDE_EN
    logic [15:0]   stride;
`endif

    ram_stream_reader_if #(.dw(dw)) out_if ();

    ram_stream_reader #(.aw(aw), .dw(dw)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .base_addr_i (base_addr),
        .len_i       (len),
`ifdef RAM_STREAM_STRIDE_EN
        .stride_i    (stride),
`endif
        .busy_o      (busy),
        .done_o      (done),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_dout_i  (ram_dout),
        .out_if      (out_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [65536];
    initial for (int k = 0; k < 65536; k++) mem[k] = 16'(k + 'h1000);
    always @(posedge clk) ram_dout <= mem[ram_addr];

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] addr_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          start_e = 0;
    int          n_words, n_valid, n_busy, n_done, first_valid_rel, done_rel;
    logic        busy_at_done;
    logic        addr_watch;
    logic [15:0] last_addr = 16'h0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0;
    int          ready_mode = 0;
    int          pidx = 0;
    logic [5:0]  ready_pat = 6'b101001;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    initial begin
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    out_if.ready = ready_pat[pidx];
                    pidx = (pidx + 1) % 6;
                end
                2:       out_if.ready = 1'b0;
                default: out_if.ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        int rel;
        exp_t e;
        logic [15:0] a;
        rel = cyc - start_e + 1;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {15'b0, out_if.valid, out_if.data}, {15'b0, 1'b1, prev_data});
            if (out_if.valid) begin
                n_valid++;
                if (first_valid_rel == 0) first_valid_rel = rel;
            end
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                done_rel = rel;
                busy_at_done = busy;
            end
            if (out_if.valid && out_if.ready) begin
                n_words++;
                if (sb.size() == 0) begin
                    check("extra_word", 32'(out_if.data), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("data", 32'(out_if.data), 32'(e.data));
                    check("last", 32'(out_if.last), 32'(e.last));
                    check("ram_we", 32'(ram_we), 32'd0);
                end
            end
            prev_stall = out_if.valid && !out_if.ready;
            prev_data  = out_if.data;
            if (addr_watch && ram_addr != last_addr) begin
                if (addr_q.size() == 0) begin
                    check("extra_addr", 32'(ram_addr), 32'hFFFF_FFFF);
                end else begin
                    a = addr_q.pop_front();
                    check("ram_addr", 32'(ram_addr), 32'(a));
                end
            end
        end
        last_addr = ram_addr;
    end

    task automatic start_xfer(input logic [15:0] b, input logic [15:0] l, input logic [15:0] s);
        logic [15:0] a;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(l); i++) begin
            a = b + 16'(i) * s;
            sb.push_back('{data: 16'(a + 16'h1000), last: (i == int'(l) - 1)});
        end
        n_words = 0; n_valid = 0; n_busy = 0; n_done = 0;
        first_valid_rel = 0; done_rel = 0; busy_at_done = 1'b0;
        base_addr = b;
        len       = l;
`ifdef RAM_STREAM_STRIDE_EN
        stride    = s;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        start_e = cyc;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_seen", 32'(done), 32'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; addr_watch = 1'b0;
`ifdef RAM_STREAM_STRIDE_EN
        stride = 16'd1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",     32'(busy),         32'd0);
        check("rst_done",     32'(done),         32'd0);
        check("rst_valid",    32'(out_if.valid), 32'd0);
        check("rst_last",     32'(out_if.last),  32'd0);
        check("rst_ram_addr", 32'(ram_addr),     32'd0);
        check("rst_ram_we",   32'(ram_we),       32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic transfer at full throughput
        start_xfer(16'h0010, 16'd4, 16'd1);
        wait_done(20);
        check("t1_first_valid", 32'(first_valid_rel), 32'd3);
        check("t1_done_cycle",  32'(done_rel),        32'd7);
        check("t1_done_count",  32'(n_done),          32'd1);
        check("t1_words",       32'(n_words),         32'd4);
        check("t1_busy_cycles", 32'(n_busy),          32'd7);
        check("t1_busy_at_done", 32'(busy_at_done),   32'd1);
        check("t1_sb_empty",    32'(sb.size()),       32'd0);
        check("t1_busy_after",  32'(busy),            32'd0);

        // Backpressure with toggling ready
        pidx = 0;
        ready_mode = 1;
        start_xfer(16'h0010, 16'd4, 16'd1);
        wait_done(60);
        ready_mode = 0;
        check("t2_words",      32'(n_words),   32'd4);
        check("t2_done_count", 32'(n_done),    32'd1);
        check("t2_sb_empty",   32'(sb.size()), 32'd0);

        // Address wrap
        addr_q.push_back(16'hFFFE);
        addr_q.push_back(16'hFFFF);
        addr_q.push_back(16'h0000);
        addr_q.push_back(16'h0001);
        addr_watch = 1'b1;
        start_xfer(16'hFFFE, 16'd4, 16'd1);
        wait_done(20);
        addr_watch = 1'b0;
        check("t3_addr_all",  32'(addr_q.size()), 32'd0);
        check("t3_words",     32'(n_words),       32'd4);
        check("t3_sb_empty",  32'(sb.size()),     32'd0);

        // Empty transfer
        start_xfer(16'h0030, 16'd0, 16'd1);
        wait_done(10);
        check("t4_done_cycle",   32'(done_rel),     32'd1);
        check("t4_valid_cycles", 32'(n_valid),      32'd0);
        check("t4_busy_cycles",  32'(n_busy),       32'd1);
        check("t4_busy_at_done", 32'(busy_at_done), 32'd1);

        // start while busy must be ignored
        start_xfer(16'h0040, 16'd8, 16'd1);
        @(posedge clk);
        #1;
        base_addr = 16'h0080;
        len = 16'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(40);
        repeat (2) @(negedge clk);
        check("t5_words",      32'(n_words),   32'd8);
        check("t5_done_count", 32'(n_done),    32'd1);
        check("t5_sb_empty",   32'(sb.size()), 32'd0);
        check("t5_busy_after", 32'(busy),      32'd0);

        // Reset in the middle of a stalled transfer
        ready_mode = 2;
        start_xfer(16'h0000, 16'd16, 16'd1);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_valid_after_rst", 32'(out_if.valid), 32'd0);
        check("t6_busy_after_rst",  32'(busy),         32'd0);
        sb.delete();
        ready_mode = 0;
        #1;
        n_valid = 0;
        repeat (4) @(negedge clk);
        #1;
        check("t6_no_emit", 32'(n_valid), 32'd0);
        start_xfer(16'h0020, 16'd2, 16'd1);
        wait_done(20);
        check("t6_words",    32'(n_words),   32'd2);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);

`ifdef RAM_STREAM_STRIDE_EN
        start_xfer(16'h0000, 16'd3, 16'd3);
        wait_done(20);
        check("t7_words",    32'(n_words),   32'd3);
        check("t7_sb_empty", 32'(sb.size()), 32'd0);
        start_xfer(16'h0000, 16'd2, 16'd0);
        wait_done(20);
        check("t8_words",    32'(n_words),   32'd2);
        check("t8_sb_empty", 32'(sb.size()), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
